// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX->MEM bus, extracts/extends load data
// from the synchronous SRAM word, and keeps that word across MEM stalls.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [79:0] ex_to_mem_bus,
    input  logic [31:0] data_sram_rdata,
    output logic [69:0] mem_to_wb_bus,
    output logic [37:0] mem_to_id_bus,
    output logic        mem_is_load
);
    localparam int EX_TO_MEM_WD = 80;
    localparam int MEM_TO_WB_WD = 70;

    typedef enum logic {FRESH, HELD} hold_state_t;

    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_reg;
    hold_state_t             state_reg, state_next;
    logic [31:0]             rdata_hold_reg;

    logic advance, bubble, freeze;
    assign advance = ~stall[3];
    assign bubble  = stall[3] & ~stall[4];
    assign freeze  = stall[3] & stall[4];

    logic [31:0] mem_pc, ex_result, word, load_data, rf_wdata;
    logic        data_ram_en, sel_rf_res, rf_we;
    logic [3:0]  data_ram_wen, data_ram_read;
    logic [4:0]  rf_waddr;
    logic [1:0]  addr_lo;

    assign mem_pc        = ex_to_mem_bus_reg[79:48];
    assign data_ram_en   = ex_to_mem_bus_reg[47];
    assign data_ram_wen  = ex_to_mem_bus_reg[46:43];
    assign sel_rf_res    = ex_to_mem_bus_reg[42];
    assign rf_we         = ex_to_mem_bus_reg[41];
    assign rf_waddr      = ex_to_mem_bus_reg[40:36];
    assign ex_result     = ex_to_mem_bus_reg[35:4];
    assign data_ram_read = ex_to_mem_bus_reg[3:0];
    assign addr_lo       = ex_result[1:0];

    assign mem_is_load = data_ram_en & (data_ram_wen == 4'b0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_to_mem_bus_reg <= '0;
        end else if (bubble) begin
            ex_to_mem_bus_reg <= '0;
        end else if (advance) begin
            ex_to_mem_bus_reg <= ex_to_mem_bus;
        end
    end

    // The SRAM word is only valid for one cycle, so capture it on the first stalled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FRESH;
            rdata_hold_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == FRESH && freeze && mem_is_load) begin
                rdata_hold_reg <= data_sram_rdata;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (advance || bubble) begin
            state_next = FRESH;
        end else if (state_reg == FRESH && mem_is_load) begin
            state_next = HELD;
        end
    end

    assign word = (state_reg == HELD) ? rdata_hold_reg : data_sram_rdata;

    logic [7:0]  word_bytes [4];
    logic [15:0] word_halves [2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign word_bytes[gi] = word[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_halves
            assign word_halves[gi] = word[16*gi +: 16];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    assign sel_byte = word_bytes[addr_lo];
    assign sel_half = word_halves[addr_lo[1]];

    always_comb begin
        load_data = '0;
        case (data_ram_read)
            4'b0001: load_data = word;
            4'b0010: load_data = {{24{sel_byte[7]}}, sel_byte};
            4'b0011: load_data = {24'b0, sel_byte};
            4'b0100: load_data = {{16{sel_half[15]}}, sel_half};
            4'b0110: load_data = {16'b0, sel_half};
            default: load_data = '0;
        endcase
    end

    assign rf_wdata = sel_rf_res ? load_data : ex_result;

    logic [MEM_TO_WB_WD-1:0] wb_bus;
    assign wb_bus        = {mem_pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_wb_bus = wb_bus;
    assign mem_to_id_bus = wb_bus[37:0];

endmodule
